// File: rtl/mpx_rr_arbiter.sv
// mpx_rr_arbiter: round-robin arbiter sharing one 4:1 datapath mux among
// four requesters (A..D). The winning word is captured into a single-entry
// holding stage that is drained through a valid/ready handshake.
// Optional feature: define MPX_ARB_LOCK_EN to add the i_lock port and a
// per-requester grant lock bounded by LOCK_MAX consecutive grants.

// Plain 4:1 word multiplexer; select values 0..3 map to inputs A..D.
module mpx_4to1 #(
    parameter int NB_DATA = 32,
    parameter int NB_SEL  = 2
) (
    input  logic [NB_SEL-1:0]  i_sel,
    input  logic [NB_DATA-1:0] i_data_a,
    input  logic [NB_DATA-1:0] i_data_b,
    input  logic [NB_DATA-1:0] i_data_c,
    input  logic [NB_DATA-1:0] i_data_d,
    output logic [NB_DATA-1:0] o_data
);

    // Select one of the four input words.
    always_comb begin
        case (i_sel)
            2'd0:    o_data = i_data_a;
            2'd1:    o_data = i_data_b;
            2'd2:    o_data = i_data_c;
            default: o_data = i_data_d;
        endcase
    end

endmodule

module mpx_rr_arbiter #(
    parameter int NB_DATA  = 32,
    parameter int NB_SEL   = 2,
    parameter int LOCK_MAX = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [3:0]         i_req,
    input  logic [NB_DATA-1:0] i_data_a,
    input  logic [NB_DATA-1:0] i_data_b,
    input  logic [NB_DATA-1:0] i_data_c,
    input  logic [NB_DATA-1:0] i_data_d,
    output logic [3:0]         o_gnt,
    output logic [NB_SEL-1:0]  o_sel,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_valid,
    input  logic               i_ready
`ifdef MPX_ARB_LOCK_EN
    ,
    input  logic [3:0]         i_lock
`endif
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t              state, state_nx;
    logic [NB_SEL-1:0]   ptr;      // last winner; search starts after it
    logic [NB_SEL-1:0]   win;
    logic                win_found;
    logic                arb_en;
    logic                grant;
    logic                lock_act;
    logic [3:0]          eff_req;
    logic [3:0]          elig;
    logic [NB_SEL-1:0]   base;
    logic [NB_DATA-1:0]  mux_out;

    if (LOCK_MAX < 1) begin : g_lock_max_check
        $error("LOCK_MAX must be at least 1");
    end

    // A new word may be captured when the holding stage is empty or is
    // being drained in this same cycle.
    assign arb_en  = (state == IDLE) | ((state == HOLD) & i_ready);

    // The requester granted last cycle still shows its request; mask it so
    // it cannot be granted twice for the same word.
    assign eff_req = i_req & ~o_gnt;

`ifdef MPX_ARB_LOCK_EN
    localparam int NB_CNT = $clog2(LOCK_MAX + 1);
    logic [NB_CNT-1:0] lock_cnt;

    assign lock_act = i_lock[ptr] & i_req[ptr] & (lock_cnt < NB_CNT'(LOCK_MAX));

    // Count consecutive locked grants; any unlocked grant or a dropped lock
    // on the current owner clears the count.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            lock_cnt <= '0;
        else if (!i_lock[ptr])
            lock_cnt <= '0;
        else if (grant) begin
            if (lock_act)
                lock_cnt <= lock_cnt + NB_CNT'(1);
            else
                lock_cnt <= '0;
        end
    end
`else
    assign lock_act = 1'b0;
`endif

    // While locked only the owner is eligible (and it stalls in its own
    // mask cycle); otherwise search ptr+1, ptr+2, ptr+3, ptr.
    always_comb begin
        logic [NB_SEL-1:0] idx;
        base      = lock_act ? ptr : ptr + NB_SEL'(1);
        elig      = lock_act ? (eff_req & (4'b0001 << ptr)) : eff_req;
        win       = '0;
        win_found = 1'b0;
        idx       = '0;
        for (int k = 0; k < 4; k++) begin
            idx = base + NB_SEL'(k);
            if (!win_found && elig[idx]) begin
                win       = idx;
                win_found = 1'b1;
            end
        end
    end

    mpx_4to1 #(.NB_DATA(NB_DATA), .NB_SEL(NB_SEL)) u_mux (
        .i_sel    (win),
        .i_data_a (i_data_a),
        .i_data_b (i_data_b),
        .i_data_c (i_data_c),
        .i_data_d (i_data_d),
        .o_data   (mux_out)
    );

    // State register for the holding stage.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next state: capture on a win, empty when nothing is eligible, and
    // otherwise keep holding the unconsumed word.
    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        if (arb_en) begin
            if (win_found) begin
                state_nx = HOLD;
                grant    = 1'b1;
            end else begin
                state_nx = IDLE;
            end
        end
    end

    assign o_valid = (state == HOLD);

    // Capture the winner's word and advance the pointer; grant is a pulse.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_gnt  <= '0;
            o_sel  <= '0;
            o_data <= '0;
            ptr    <= NB_SEL'(3);
        end else begin
            o_gnt <= '0;
            if (grant) begin
                o_data <= mux_out;
                o_sel  <= win;
                o_gnt  <= 4'b0001 << win;
                ptr    <= win;
            end
        end
    end

endmodule

// File: tb/tb_mpx_rr_arbiter.sv
// Bench for mpx_rr_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_mpx_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] da, db, dc, dd;
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic [31:0] data;
    logic        valid;
    logic        ready;
    logic [3:0]  lock = 4'b0000;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mpx_rr_arbiter #(.NB_DATA(32), .NB_SEL(2), .LOCK_MAX(8)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_req    (req),
        .i_data_a (da),
        .i_data_b (db),
        .i_data_c (dc),
        .i_data_d (dd),
        .o_gnt    (gnt),
        .o_sel    (sel),
        .o_data   (data),
        .o_valid  (valid),
        .i_ready  (ready)
`ifdef MPX_ARB_LOCK_EN
        ,
        .i_lock   (lock)
`endif
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: holding stage is either full or empty; on each edge
    // a word may be taken when empty or drained, picking the first requester
    // after the last winner in circular order, excluding the one just granted.
    int          m_ptr;
    bit          m_valid;
    logic [3:0]  m_gnt;
    int          m_sel;
    logic [31:0] m_data;

    always @(posedge clk) begin
        logic [31:0] words [4];
        logic [3:0]  cand;
        int          w;
        words = '{da, db, dc, dd};
        if (!rst_n) begin
            m_valid = 0; m_gnt = 0; m_sel = 0; m_data = 0; m_ptr = 3;
        end else begin
            logic [3:0] g;
            g = 0;
            if (!m_valid || ready) begin
                cand = req & ~m_gnt;
                w = -1;
                for (int k = 1; k <= 4; k++)
                    if (w < 0 && cand[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
                if (w >= 0) begin
                    m_data = words[w]; m_sel = w; m_ptr = w; m_valid = 1;
                    g[w] = 1'b1;
                end else begin
                    m_valid = 0;
                end
            end
            m_gnt = g;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("mdl_valid", 32'(valid), 32'(m_valid));
            check("mdl_gnt",   32'(gnt),   32'(m_gnt));
            check("mdl_sel",   32'(sel),   32'(m_sel));
            check("mdl_data",  data,       m_data);
        end
    end

    // Advance one clock; inputs are driven on negedges.
    task automatic nxt();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        nxt();
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_gnt",   32'(gnt),   32'd0);
        check("rst_sel",   32'(sel),   32'd0);
        check("rst_data",  data,       32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] exp_rot [5];
        exp_rot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst_n = 1'b0; req = 4'b0000; ready = 1'b1;
        da = 32'hAAAAAAAA; db = 32'hBBBBBBBB; dc = 32'hCCCCCCCC; dd = 32'hDDDDDDDD;
        @(negedge clk);
        nxt();
        chk_en = 1'b1;

        // All four requesting: rotation 0,1,2,3,0.
        req = 4'b1111;
        do_reset();
        nxt();
        check("rot0_data", data, 32'hAAAAAAAA);
        check("rot0_sel",  32'(sel), 32'd0);
        check("rot0_gnt",  32'(gnt), 32'(exp_rot[0]));
        for (int i = 1; i < 5; i++) begin
            nxt();
            check("rot_gnt", 32'(gnt), 32'(exp_rot[i]));
        end

        // Lone requester 2: grants only on every other cycle.
        req = 4'b0100;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            nxt();
            check("solo_gnt", 32'(gnt), (i % 2 == 0) ? 32'h4 : 32'h0);
            if (i % 2 == 0) check("solo_data", data, 32'hCCCCCCCC);
        end

        // Back-pressure: word A held while not ready, then B follows.
        req = 4'b0011; ready = 1'b0;
        do_reset();
        nxt();
        check("bp_gnt0", 32'(gnt), 32'h1);
        for (int i = 0; i < 5; i++) begin
            nxt();
            check("bp_valid", 32'(valid), 32'd1);
            check("bp_data",  data, 32'hAAAAAAAA);
            check("bp_sel",   32'(sel), 32'd0);
            check("bp_gnt",   32'(gnt), 32'd0);
        end
        ready = 1'b1;
        nxt();
        check("bp_gnt1",  32'(gnt), 32'h2);
        check("bp_data1", data, 32'hBBBBBBBB);

        // Reset while holding a word discards it; pending A wins first.
        ready = 1'b0;
        nxt();
        check("hold_valid", 32'(valid), 32'd1);
        do_reset();
        nxt();
        check("post_rst_gnt", 32'(gnt), 32'h1);

        // HOLD with ptr=3; A and D raised together with ready: A then D.
        req = 4'b1000; ready = 1'b0;
        do_reset();
        nxt();
        check("d_gnt", 32'(gnt), 32'h8);
        req = 4'b0000;
        nxt();
        req = 4'b1001; ready = 1'b1;
        nxt();
        check("ad_first", 32'(gnt), 32'h1);
        nxt();
        check("ad_second", 32'(gnt), 32'h8);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 79) != 0);
            req   = 4'($urandom);
            ready = ($urandom_range(0, 3) != 0);
            da = $urandom; db = $urandom; dc = $urandom; dd = $urandom;
            nxt();
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mpx_rr_arbiter.md
Name: mpx_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one NB_DATA-wide 4:1 datapath multiplexer among four requesters (A..D).
- Instantiates mpx_4to1 internally. Drives its select from the arbitration result and registers the selected word into a single-entry output holding stage with a valid/ready handshake.
- Used wherever several MIPS pipeline sources compete for one shared bus, e.g. the debug/UART readout path.

Parameters:
- NB_DATA, 32, width of each data input and of o_data.
- NB_SEL, 2, select width passed to mpx_4to1; fixed at 2 (four requesters).
- LOCK_MAX, 8, maximum consecutive locked grants to one requester (used only with MPX_ARB_LOCK_EN).

Ports:
- i_clk  in  1  system clock; all logic on the rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_req  in  4  request per requester; bit k = requester k (0=A..3=D).
- i_data_a  in  NB_DATA  requester 0 data; held stable while i_req[0]=1 until o_gnt[0].
- i_data_b  in  NB_DATA  requester 1 data, same rule.
- i_data_c  in  NB_DATA  requester 2 data, same rule.
- i_data_d  in  NB_DATA  requester 3 data, same rule.
- o_gnt  out  4  one-hot, one-cycle pulse: the requester's word has been captured.
- o_sel  out  NB_SEL  index of the last winner (mux select of the captured word).
- o_data  out  NB_DATA  captured word.
- o_valid  out  1  o_data holds an unconsumed word.
- i_ready  in  1  consumer accepts o_data when o_valid & i_ready at a rising edge.
- i_lock  in  4  per-requester lock request; present only with MPX_ARB_LOCK_EN.

Behaviour:
- Reset (i_rst_n=0 at an edge): o_valid=0, o_gnt=0, o_sel=0, o_data=0, priority pointer ptr=3 (requester 0 wins first), lock counter=0, state=IDLE.
- Reset mid-operation: any held word is discarded and not re-presented. A requester pending at reset keeps i_req high and is arbitrated normally after reset.
- States:
  - IDLE: o_valid=0.
  - HOLD: o_valid=1, o_data/o_sel frozen.
- Arbitration enable (arb_en) = (state==IDLE) | (state==HOLD & i_ready).
- Effective request = i_req & ~o_gnt. The requester granted this cycle is masked, so a request not yet withdrawn is never double-granted.
- Priority order from ptr: ptr+1, ptr+2, ptr+3, ptr (mod 4). The highest-priority effective request wins.
- At an edge with arb_en and a non-zero effective request:
  - mux select = winner; o_data <= mux output; o_sel <= winner.
  - o_gnt <= onehot(winner); ptr <= winner; state <= HOLD.
- At an edge with arb_en and no effective request: state <= IDLE, o_valid <= 0.
- At an edge in HOLD with i_ready=0: everything holds; o_gnt <= 0.
- o_gnt is high for exactly one cycle per captured word. In that same cycle o_valid is 1 and o_sel equals the granted index.
- Latency:
  - Request seen at edge N (IDLE) -> o_valid, o_data and o_gnt valid in cycle N+1.
  - Sustained throughput is one word per cycle when i_ready is held high and at least one other requester is pending.
  - A single requester alone gets at most one grant every 2 cycles (due to masking).
- All four requesting continuously with i_ready=1: grants rotate 0,1,2,3,0...; no requester waits more than 3 grants.
- Unused select values cannot occur (4 inputs, NB_SEL=2). No arithmetic beyond the 2-bit modulo-4 pointer increment, which wraps 3->0.

Optional Feature:
- Macro: MPX_ARB_LOCK_EN.
- Defined:
  - i_lock port exists.
  - If i_lock[ptr]=1 and i_req[ptr]=1 and lock count < LOCK_MAX, only requester ptr is eligible, and priority starts at ptr instead of ptr+1.
  - In its mask cycle no grant is issued: the arbiter stalls, it does not grant others.
  - Lock counter increments per locked grant. It resets to 0 on any grant to a different requester or when i_lock[ptr]=0.
  - At LOCK_MAX the lock is ignored for one arbitration (normal round-robin).
- Not defined: no i_lock port, plain round-robin as above, lock counter not synthesised.

Test Plan:
- Reset with i_req=4'b1111 held, release -> first o_gnt=4'b0001, o_sel=0, o_data=i_data_a (0xAAAAAAAA), then 0010, 0100, 1000, 0001 on consecutive cycles with i_ready=1.
- Only i_req[2] held, data 0xCCCCCCCC, i_ready=1 -> grants to 2 on every other cycle, never on consecutive cycles; o_data=0xCCCCCCCC.
- i_req=4'b0011, i_ready=0 for 5 cycles after first grant -> o_valid=1, o_data=0xAAAAAAAA, o_sel=0 stable, no further o_gnt. Raise i_ready -> next grant 0010, o_data=0xBBBBBBBB.
- Assert i_rst_n=0 while in HOLD with o_valid=1 -> next cycle o_valid=0, o_gnt=0, o_data=0, o_sel=0. After release, pending requester 0 is granted first.
- Simultaneous new request and i_ready in HOLD (ptr=3, i_req=4'b1000 newly raised with 4'b0001) -> requester 0 wins (priority ptr+1=0), requester 3 next.
- MPX_ARB_LOCK_EN, LOCK_MAX=8, i_lock[1]=1, i_req=4'b0011 continuous -> requester 1 gets 8 consecutive locked grants with a stall cycle between each, then requester 0 is granted once, then lock resumes.
